// File: rtl/display_pkg.sv
// Shared constants for the two-digit display formatter and its BCD step.
package display_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int DISPLAY_DIGITS       = 2;
    localparam int BCD_WIDTH            = 12;
    localparam int BCD_ITERATIONS       = 8;
    localparam int BCD_ADJUST_THRESHOLD = 5;
    localparam int BCD_ADJUST_ADD       = 3;
    localparam int SR_WIDTH             = BCD_WIDTH + 8;
endpackage

// File: rtl/display_bcd_step.sv
// One double-dabble iteration: +3 on each BCD nibble >= 5, then shift left by one.
module display_bcd_step
    import display_pkg::*;
(
    input  logic [SR_WIDTH-1:0] sr_in,
    output logic [SR_WIDTH-1:0] sr_out
);
    logic [SR_WIDTH-1:0] adj;

    always_comb begin
        adj = sr_in;
        for (int d = 0; d < BCD_WIDTH / 4; d++) begin
            if (adj[8 + 4*d +: 4] >= 4'(BCD_ADJUST_THRESHOLD))
                adj[8 + 4*d +: 4] = adj[8 + 4*d +: 4] + 4'(BCD_ADJUST_ADD);
        end
        sr_out = {adj[SR_WIDTH-2:0], 1'b0};
    end
endmodule

// File: rtl/display_value_formatter.sv
// Formats an 8-bit value as hex or two BCD digits for the seven-segment driver.
// Decimal mode exists only when DISPLAY_FMT_DECIMAL_EN is defined.
module display_value_formatter
    import display_pkg::*;
#(
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [7:0] i_value,
    input  logic       i_decimal,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_overflow,
    output logic       o_busy
);
`ifdef DISPLAY_FMT_DECIMAL_EN
    state_t              state;
    logic [SR_WIDTH-1:0] sr;
    logic [SR_WIDTH-1:0] sr_next;
    logic [2:0]          cnt;

    display_bcd_step u_step (
        .sr_in  (sr),
        .sr_out (sr_next)
    );

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            o_data     <= RESET_DATA;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_decimal) begin
                            sr    <= {{BCD_WIDTH{1'b0}}, i_value};
                            cnt   <= '0;
                            state <= CONVERT;
                        end else begin
                            o_data     <= i_value;
                            o_overflow <= 1'b0;
                        end
                    end
                end
                CONVERT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 3'd1;
                    // Result is taken from the 8th shifted value, so it lands on the same edge.
                    if (cnt == 3'(BCD_ITERATIONS - 1)) begin
                        o_data     <= sr_next[15:8];
                        o_overflow <= |sr_next[19:16];
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
`else
    logic unused_decimal;
    assign unused_decimal = i_decimal;

    always_ff @(posedge i_clk) begin
        if (!i_resetn)
            o_data <= RESET_DATA;
        else if (i_valid)
            o_data <= i_value;
    end

    assign o_ready    = 1'b1;
    assign o_overflow = 1'b0;
`endif
    assign o_busy = ~o_ready;
endmodule
